bcd_seven_seg_scanner: RTL and testbench

Consumes the packed BCD word produced by the binary-to-BCD converter and drives a time-multiplexed multi-digit seven-segment display.
- Latches new BCD values through a load strobe.
- Commits them only at frame boundaries, so no partially updated frame is ever shown.
- Scans the digits with a refresh divider.
- Optionally blanks leading zeros.
- Sits between the converter and the board display pins.

---
 rtl/seven_seg_pkg.sv | 29 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/bcd_seven_seg_scanner.sv | 150 +++++++++++++++
 tb/tb_bcd_seven_seg_scanner.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment encoding: segment bit order and high-true glyph codes.
package seven_seg_pkg;

  // Segment vector layout is {g,f,e,d,c,b,a}; bit 0 is segment a.
  typedef logic [6:0] seg_t;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // High-true glyph codes (1 = segment lit).
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD nibble to high-true seven-segment decoder; non-BCD shows a dash.
module bcd_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  // Glyph lookup; nibbles 10-15 fall through to the dash.
  always_comb begin
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seven_seg_scanner.sv
// Multiplexed seven-segment scanner: buffers BCD loads, commits them at frame
// boundaries, scans digits with a refresh divider and optionally blanks leading zeros.
module bcd_seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int DIGITS     = 2,
  parameter int CLK_DIV    = 4,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam seg_t              SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_v_q, pend_v_d;
  seg_t                seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q, fd_d;

  logic                cnt_end_s;
  logic                boundary_s;
  logic [4*DIGITS-1:0] shifted_s;
  logic [3:0]          nibble_s;
  seg_t                code_s;
  seg_t                seg_hi_s;
  logic [DIGITS-1:0]   blank_s;
  logic [DIGITS-1:0]   onehot_s;
  logic                zero_run_s;

  // Divider, digit index and the pending/display hand-off at frame boundaries.
  always_comb begin
    cnt_end_s  = (cnt_q == CNT_W'(CLK_DIV - 1));
    boundary_s = cnt_end_s && (idx_q == IDX_W'(DIGITS - 1));

    if (cnt_end_s) begin
      cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_W'(DIGITS - 1)) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      idx_d = idx_q;
    end

    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (load) begin
      if (boundary_s) begin
        // A load landing on the boundary goes straight to the next frame.
        disp_d   = bcd_in;
        pend_v_d = 1'b0;
      end else begin
        pend_d   = bcd_in;
        pend_v_d = 1'b1;
      end
    end else if (boundary_s && pend_v_q) begin
      disp_d   = pend_q;
      pend_v_d = 1'b0;
    end else begin
      pend_v_d = pend_v_q;
    end
  end

  // Leading-zero mask: digit i blanks when it and every higher digit are zero.
  always_comb begin
    zero_run_s = 1'b1;
    blank_s    = {DIGITS{1'b0}};
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (disp_q[4*i +: 4] == 4'h0);
      blank_s[i] = blank_lz & zero_run_s;
    end
  end

  // Select the active digit's nibble for the decoder.
  always_comb begin
    shifted_s = disp_q >> {idx_q, 2'b00};
    nibble_s  = shifted_s[3:0];
  end

  bcd_to_seg u_dec (
    .nibble_i (nibble_s),
    .seg_o    (code_s)
  );

  // Next output values: anode one-hot, blanking and board polarity.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      onehot_s[i] = (idx_q == IDX_W'(i));
    end
    if (blank_s[idx_q]) begin
      seg_hi_s = SEG_BLANK;
    end else begin
      seg_hi_s = code_s;
    end
    if (ACTIVE_LOW != 0) begin
      seg_d = ~seg_hi_s;
      an_d  = ~onehot_s;
    end else begin
      seg_d = seg_hi_s;
      an_d  = onehot_s;
    end
    fd_d = boundary_s;
  end

  // State and registered outputs; synchronous reset discards pending data.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= {CNT_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      disp_q   <= {(4*DIGITS){1'b0}};
      pend_q   <= {(4*DIGITS){1'b0}};
      pend_v_q <= 1'b0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// Scoreboard bench for bcd_seven_seg_scanner (DIGITS=2, CLK_DIV=4, ACTIVE_LOW=1).
module tb_bcd_seven_seg_scanner;

  localparam int DIGITS  = 2;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = DIGITS * CLK_DIV;

  logic       clk;
  logic       reset;
  logic [7:0] bcd_in;
  logic       load;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_done;

  int n_cmp;
  int n_err;

  // Reference model state: position within frame, shown value, pending value.
  int         m_t;
  logic [7:0] m_disp;
  logic [7:0] m_pend;
  logic       m_pv;

  logic [9:0] exp_q[$];

  bcd_seven_seg_scanner #(
    .DIGITS     (DIGITS),
    .CLK_DIV    (CLK_DIV),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bcd_in     (bcd_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .an         (an),
    .frame_done (frame_done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
  endfunction

  // One clock: drive inputs, push expected outputs, then compare after the edge.
  task automatic cyc(input logic r, input logic ld, input logic [7:0] v, input logic blz);
    logic [6:0] code;
    logic [6:0] es;
    logic [1:0] ea;
    logic       ef;
    logic [9:0] e;
    int         dg;
    reset    = r;
    load     = ld;
    bcd_in   = v;
    blank_lz = blz;
    if (r) begin
      es = 7'h7F; ea = 2'b11; ef = 1'b0;
      m_t = 0; m_disp = 8'h00; m_pend = 8'h00; m_pv = 1'b0;
    end else begin
      dg   = m_t / CLK_DIV;
      code = glyph(m_disp[4*dg +: 4]);
      if (blz && dg > 0 && ((m_disp >> (4*dg)) == 8'h00)) code = 7'h00;
      es = ~code;
      ea = ~(2'b01 << dg);
      ef = (m_t == FRAME - 1);
      if (ld) begin
        if (m_t == FRAME - 1) begin
          m_disp = v; m_pv = 1'b0;
        end else begin
          m_pend = v; m_pv = 1'b1;
        end
      end else if (m_t == FRAME - 1 && m_pv) begin
        m_disp = m_pend; m_pv = 1'b0;
      end
      m_t = (m_t + 1) % FRAME;
    end
    exp_q.push_back({es, ea, ef});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq("seg", {25'd0, seg}, {25'd0, e[9:3]});
      check_eq("an", {30'd0, an}, {30'd0, e[2:1]});
      check_eq("frame_done", {31'd0, frame_done}, {31'd0, e[0]});
    end
  endtask

  task automatic idle(input int n, input logic blz);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, blz);
  endtask

  // Idle until the model reaches a given frame position (at most one frame).
  task automatic run_until(input int ph, input logic blz);
    for (int k = 0; k < FRAME && m_t != ph; k++) cyc(1'b0, 1'b0, 8'h00, blz);
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    m_t = 0; m_disp = 8'h00; m_pend = 8'h00; m_pv = 1'b0;
    reset = 1'b1; load = 1'b0; bcd_in = 8'h00; blank_lz = 1'b0;

    // Reset held three cycles, then "00" with frame pulses.
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check_eq("rst_seg_direct", {25'd0, seg}, 32'h7F);
    check_eq("rst_an_direct", {30'd0, an}, 32'h3);
    idle(16, 1'b0);

    // Plain load shows after the next boundary.
    cyc(1'b0, 1'b1, 8'h15, 1'b0);
    idle(20, 1'b0);

    // Leading-zero blanking on and off.
    cyc(1'b0, 1'b1, 8'h07, 1'b1);
    idle(20, 1'b1);
    idle(10, 1'b0);

    // Invalid upper nibble decodes to a dash.
    cyc(1'b0, 1'b1, 8'hA3, 1'b0);
    idle(20, 1'b0);

    // No tearing: load during digit 0 phase while 47 is displayed.
    cyc(1'b0, 1'b1, 8'h47, 1'b0);
    run_until(0, 1'b0);
    idle(FRAME, 1'b0);
    run_until(1, 1'b0);
    cyc(1'b0, 1'b1, 8'h12, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Two loads in one frame: last one wins.
    run_until(1, 1'b0);
    cyc(1'b0, 1'b1, 8'h12, 1'b0);
    run_until(3, 1'b0);
    cyc(1'b0, 1'b1, 8'h34, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Load on the boundary cycle itself.
    run_until(FRAME - 1, 1'b0);
    cyc(1'b0, 1'b1, 8'h86, 1'b0);
    idle(2 * FRAME, 1'b0);

    // Reset mid digit-1 phase discards a pending value.
    run_until(1, 1'b0);
    cyc(1'b0, 1'b1, 8'h99, 1'b0);
    run_until(5, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    idle(3 * FRAME, 1'b0);
    idle(3 * FRAME, 1'b1);

    // Random loads and blanking.
    for (int k = 0; k < 300; k++) begin
      cyc(1'b0, ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)),
          ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
